paillier_task_scheduler: RTL

Sequences a Paillier job (encryption, decryption, homomorphic add or scalar multiply) across BLOCK_COUNT parallel compute cores that share one AXI-full DMA engine. The host's AXI-lite registers supply mode, task count and start. The scheduler then issues operand reads, starts cores, and writes results back through the single DMA port until every task has completed. It sits between the AXI-lite register core, the AXI-full master DMA and the core array inside the Paillier AXI top.

---
 rtl/paillier_sched_pkg.sv | 28 ++
 rtl/paillier_rr_pick.sv | 28 ++
 rtl/paillier_task_scheduler.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/paillier_sched_pkg.sv
// Shared mode encodings, FSM state type and per-mode read sizing for the Paillier task scheduler.
package paillier_sched_pkg;

  localparam logic [1:0] STA_ENCRYPTION      = 2'b00;
  localparam logic [1:0] STA_DECRYPTION      = 2'b01;
  localparam logic [1:0] STA_HOMOMORPHIC_ADD = 2'b10;
  localparam logic [1:0] STA_SCALAR_MUL      = 2'b11;

  typedef enum logic [2:0] {
    StIdle,
    StScan,
    StRdReq,
    StCoreGo,
    StWrReq,
    StFinish
  } sched_state_e;

  // Operand units fetched per task; decryption needs only the ciphertext.
  function automatic logic [1:0] rd_units(input logic [1:0] mode);
    logic [1:0] units;
    case (mode)
      STA_DECRYPTION: units = 2'd1;
      default:        units = 2'd2;
    endcase
    return units;
  endfunction

endpackage

// File: rtl/paillier_rr_pick.sv
// Combinational round-robin selector: first free core at or after ptr, wrapping.
module paillier_rr_pick #(
  parameter int unsigned BLOCK_COUNT = 10
) (
  input  logic [BLOCK_COUNT-1:0]         busy,
  input  logic [$clog2(BLOCK_COUNT)-1:0] ptr,
  output logic [$clog2(BLOCK_COUNT)-1:0] idx,
  output logic                           found
);

  localparam int unsigned IdxW = $clog2(BLOCK_COUNT);

  always_comb begin
    int unsigned cand;
    found = 1'b0;
    idx   = '0;
    cand  = 0;
    for (int unsigned k = 0; k < BLOCK_COUNT; k++) begin
      cand = k + 32'(ptr);
      if (cand >= BLOCK_COUNT) cand = cand - BLOCK_COUNT;
      if (!found && !busy[cand]) begin
        found = 1'b1;
        idx   = IdxW'(cand);
      end
    end
  end

endmodule

// File: rtl/paillier_task_scheduler.sv
// Dispatches Paillier tasks to BLOCK_COUNT cores through one shared DMA read/write port and
// collects results until every task of the job has been written back.
module paillier_task_scheduler
  import paillier_sched_pkg::*;
#(
  parameter int unsigned BLOCK_COUNT    = 10,
  parameter int unsigned K              = 128,
  parameter int unsigned N              = 32,
  parameter logic [63:0] TARGET_RD_ADDR = 64'h0,
  parameter logic [63:0] TARGET_WR_ADDR = 64'h0
) (
  input  logic                           M_AXI_ACLK,
  input  logic                           M_AXI_ARESET,
  input  logic                           start,
  input  logic [1:0]                     mode,
  input  logic [63:0]                    test_times,
  output logic                           busy,
  output logic                           done,
  output logic                           err,
  output logic [1:0]                     core_mode,
  output logic [BLOCK_COUNT-1:0]         core_start,
  input  logic [BLOCK_COUNT-1:0]         core_done,
  output logic                           dma_rd_req,
  output logic [63:0]                    dma_rd_addr,
  output logic [15:0]                    dma_rd_len,
  output logic [$clog2(BLOCK_COUNT)-1:0] dma_rd_core,
  input  logic                           dma_rd_ack,
  output logic                           dma_wr_req,
  output logic [63:0]                    dma_wr_addr,
  output logic [15:0]                    dma_wr_len,
  output logic [$clog2(BLOCK_COUNT)-1:0] dma_wr_core,
  input  logic                           dma_wr_ack
);

  localparam int unsigned IdxW      = $clog2(BLOCK_COUNT);
  localparam logic [63:0] UnitBytes = 64'(K * N / 8);

  sched_state_e state_q, state_d;

  logic [1:0]             mode_q;
  logic [63:0]            tt_q, issued_q, completed_q;
  logic [63:0]            tag_q [BLOCK_COUNT];
  logic [BLOCK_COUNT-1:0] busy_vec_q, busy_vec_d, pending_q, pending_d;
  logic                   err_q, err_d;
  logic [IdxW-1:0]        sel_q, sel_d, rr_ptr_q;
  logic [IdxW-1:0]        free_idx, pend_idx;
  logic                   free_found, pend_found;
  logic                   accept_start, rd_fire, wr_fire;
  logic [1:0]             units;

  assign accept_start = (state_q == StIdle) && start;
  assign rd_fire      = (state_q == StRdReq) && dma_rd_ack;
  assign wr_fire      = (state_q == StWrReq) && dma_wr_ack;
  assign units        = rd_units(mode_q);

  paillier_rr_pick #(
    .BLOCK_COUNT(BLOCK_COUNT)
  ) u_rr_pick (
    .busy  (busy_vec_q),
    .ptr   (rr_ptr_q),
    .idx   (free_idx),
    .found (free_found)
  );

  // Lowest-index pending result wins write-back.
  always_comb begin
    pend_found = 1'b0;
    pend_idx   = '0;
    for (int i = BLOCK_COUNT - 1; i >= 0; i--) begin
      if (pending_q[i]) begin
        pend_found = 1'b1;
        pend_idx   = IdxW'(i);
      end
    end
  end

  always_ff @(posedge M_AXI_ACLK) begin
    if (M_AXI_ARESET) state_q <= StIdle;
    else              state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    unique case (state_q)
      StIdle:   if (start) state_d = StScan;
      StScan: begin
        if (pend_found) begin
          sel_d   = pend_idx;
          state_d = StWrReq;
        end else if ((issued_q < tt_q) && free_found) begin
          sel_d   = free_idx;
          state_d = StRdReq;
        end else if (completed_q == tt_q) begin
          state_d = StFinish;
        end
      end
      StRdReq:  if (dma_rd_ack) state_d = StCoreGo;
      StCoreGo: state_d = StScan;
      StWrReq:  if (dma_wr_ack) state_d = StScan;
      StFinish: state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  always_comb begin
    busy        = (state_q != StIdle);
    done        = (state_q == StFinish);
    core_start  = '0;
    dma_rd_req  = 1'b0;
    dma_rd_addr = '0;
    dma_rd_len  = '0;
    dma_rd_core = '0;
    dma_wr_req  = 1'b0;
    dma_wr_addr = '0;
    dma_wr_len  = '0;
    dma_wr_core = '0;
    unique case (state_q)
      StRdReq: begin
        dma_rd_req  = 1'b1;
        dma_rd_addr = TARGET_RD_ADDR + issued_q * {62'd0, units} * UnitBytes;
        dma_rd_len  = UnitBytes[15:0] * {14'd0, units};
        dma_rd_core = sel_q;
      end
      StCoreGo: core_start = BLOCK_COUNT'(1) << sel_q;
      StWrReq: begin
        dma_wr_req  = 1'b1;
        dma_wr_addr = TARGET_WR_ADDR + tag_q[sel_q] * UnitBytes;
        dma_wr_len  = UnitBytes[15:0];
        dma_wr_core = sel_q;
      end
      default: ;
    endcase
  end

  assign err       = err_q;
  assign core_mode = mode_q;

  // Core completions are accepted in every state, alongside any DMA handshake.
  always_comb begin
    busy_vec_d = busy_vec_q;
    pending_d  = pending_q;
    err_d      = err_q;
    for (int i = 0; i < BLOCK_COUNT; i++) begin
      if (core_done[i]) begin
        if (busy_vec_q[i]) pending_d[i] = 1'b1;
        else               err_d        = 1'b1;
      end
    end
    if (rd_fire) busy_vec_d[sel_q] = 1'b1;
    if (wr_fire) begin
      busy_vec_d[sel_q] = 1'b0;
      pending_d[sel_q]  = 1'b0;
    end
    if (accept_start) err_d = 1'b0;
  end

  always_ff @(posedge M_AXI_ACLK) begin
    if (M_AXI_ARESET) begin
      mode_q      <= '0;
      tt_q        <= '0;
      issued_q    <= '0;
      completed_q <= '0;
      busy_vec_q  <= '0;
      pending_q   <= '0;
      err_q       <= 1'b0;
      sel_q       <= '0;
      rr_ptr_q    <= '0;
      for (int i = 0; i < BLOCK_COUNT; i++) tag_q[i] <= '0;
    end else begin
      busy_vec_q <= busy_vec_d;
      pending_q  <= pending_d;
      err_q      <= err_d;
      sel_q      <= sel_d;
      if (accept_start) begin
        mode_q      <= mode;
        tt_q        <= test_times;
        issued_q    <= '0;
        completed_q <= '0;
      end
      if (rd_fire) begin
        tag_q[sel_q] <= issued_q;
        issued_q     <= issued_q + 64'd1;
        rr_ptr_q     <= (sel_q == IdxW'(BLOCK_COUNT - 1)) ? '0 : sel_q + 1'b1;
      end
      if (wr_fire) completed_q <= completed_q + 64'd1;
    end
  end

endmodule
